// File: rtl/strobe_period_meter_pkg.sv
// Shared types and constants for the strobe period meter.
// Holds the FSM state encoding, default parameter values and the
// parameter legality check used at elaboration time.
package meter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEAS   = 2'd1,
      LOCKED = 2'd2
   } meter_state_e;

   localparam int DEF_CNT_W      = 16;
   localparam int DEF_EXP_PERIOD = 7;
   localparam int DEF_LOCK_CNT   = 4;
   localparam int DEF_TIMEOUT    = 1024;

   // True when 1 <= exp_period <= timeout < 2^cnt_w, timeout >= 2 and lock_cnt >= 1.
   function automatic bit params_legal(int cnt_w, int exp_period, int lock_cnt, int timeout);
      longint limit;
      limit = 64'sd1 << cnt_w;
      return (exp_period >= 32'sd1) && (exp_period <= timeout) &&
             (timeout >= 32'sd2) && (longint'(timeout) < limit) &&
             (lock_cnt >= 32'sd1) && (cnt_w >= 32'sd2) && (cnt_w <= 32'sd31);
   endfunction

endpackage

// File: rtl/strobe_period_meter_if.sv
// Strobe input / measurement result bundle of the strobe period meter.
// master = the block feeding the strobe and observing the results,
// slave  = the meter itself.
interface strobe_period_meter_if
   import meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             strobe_in;
   logic             clr;
   logic [CNT_W-1:0] period;
   logic             period_vld;
   logic             locked;
   logic             mismatch;
   logic             timeout;

   modport master (
      output strobe_in, clr,
      input  period, period_vld, locked, mismatch, timeout
   );

   modport slave (
      input  strobe_in, clr,
      output period, period_vld, locked, mismatch, timeout
   );
endinterface

// File: rtl/strobe_period_meter_sync_rise_det.sv
// Synchroniser plus rising-edge detector for an asynchronous input.
// Two flops bring the signal into the sys_clk domain, a third holds the
// previous synchronised value; rise is a one-cycle pulse per 0->1 change.
// A stuck-high input gives exactly one pulse.
module sync_rise_det (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic async_in,
   output logic rise
);
   logic s1_r;
   logic s2_r;
   logic s3_r;

   // Two-stage synchroniser followed by the edge-history flop.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= async_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign rise = s2_r & ~s3_r;
endmodule

// File: rtl/strobe_period_meter.sv
// Strobe period meter: measures the sys_clk period of an asynchronous
// strobe, compares it against EXP_PERIOD and reports lock, mismatch and
// loss-of-signal. The first rising edge after reset, clear or timeout only
// arms the meter; every later edge produces one measurement.
module strobe_period_meter
   import meter_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int EXP_PERIOD = DEF_EXP_PERIOD,
   parameter int LOCK_CNT   = DEF_LOCK_CNT,
   parameter int TIMEOUT    = DEF_TIMEOUT
)(
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   strobe_period_meter_if.slave  bus
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] EXP_V     = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_CNT);

   if (!params_legal(CNT_W, EXP_PERIOD, LOCK_CNT, TIMEOUT)) begin : g_bad_params
      $error("strobe_period_meter: illegal parameter combination");
   end

   logic             rise_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [MW-1:0]    match_inc_s;

   meter_state_e     state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [MW-1:0]    match_r;
   logic [CNT_W-1:0] period_r;
   logic             period_vld_r;
   logic             locked_r;
   logic             mismatch_r;
   logic             timeout_r;

   sync_rise_det u_sync_rise_det (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .async_in  (bus.strobe_in),
      .rise      (rise_s)
   );

   // Saturating increments: cnt stops at TIMEOUT, match counter at LOCK_CNT.
   always_comb begin
      cnt_inc_s   = cnt_r;
      match_inc_s = match_r;
      if (cnt_r < TIMEOUT_V) begin
         cnt_inc_s = cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_inc_s = cnt_r;
      end
      if (match_r < LOCK_V) begin
         match_inc_s = match_r + MW'(1'b1);
      end else begin
         match_inc_s = match_r;
      end
   end

   // Measurement FSM with registered results; clr overrides all activity.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         match_r      <= '0;
         period_r     <= '0;
         period_vld_r <= 1'b0;
         locked_r     <= 1'b0;
         mismatch_r   <= 1'b0;
         timeout_r    <= 1'b0;
      end else if (bus.clr) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         match_r      <= '0;
         period_vld_r <= 1'b0;
         locked_r     <= 1'b0;
         mismatch_r   <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         period_vld_r <= 1'b0;
         mismatch_r   <= 1'b0;
         timeout_r    <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rise_s) begin
                  state_r <= MEAS;
                  cnt_r   <= CNT_W'(1'b1);
               end else begin
                  cnt_r   <= cnt_inc_s;
               end
            end
            MEAS, LOCKED: begin
               if (rise_s) begin
                  // A rise always wins over a simultaneous timeout.
                  period_r     <= cnt_r;
                  period_vld_r <= 1'b1;
                  cnt_r        <= CNT_W'(1'b1);
                  if (cnt_r == EXP_V) begin
                     match_r <= match_inc_s;
                     if (match_inc_s == LOCK_V) begin
                        state_r  <= LOCKED;
                        locked_r <= 1'b1;
                     end else begin
                        state_r  <= state_r;
                        locked_r <= locked_r;
                     end
                  end else begin
                     mismatch_r <= 1'b1;
                     match_r    <= '0;
                     locked_r   <= 1'b0;
                     state_r    <= MEAS;
                  end
               end else if (cnt_r == TIMEOUT_V) begin
                  timeout_r <= 1'b1;
                  locked_r  <= 1'b0;
                  match_r   <= '0;
                  state_r   <= IDLE;
                  cnt_r     <= cnt_inc_s;
               end else begin
                  cnt_r     <= cnt_inc_s;
               end
            end
            default: begin
               state_r  <= IDLE;
               cnt_r    <= '0;
               match_r  <= '0;
               locked_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.period     = period_r;
   assign bus.period_vld = period_vld_r;
   assign bus.locked     = locked_r;
   assign bus.mismatch   = mismatch_r;
   assign bus.timeout    = timeout_r;
endmodule

// File: doc/strobe_period_meter.md
Name: strobe_period_meter

Overview:
- Receiving end of the team's clock-divider tick outputs. Takes an asynchronous periodic strobe, such as a divider tick looped back over GPIO.
- Measures the strobe period in sys_clk cycles, compares it to an expected period, and reports lock, mismatch and loss-of-signal (timeout).
- Used as an on-board checker for divider blocks and as a general frequency monitor.

Parameters:
- CNT_W, 16, width of the period counter and the period output.
- EXP_PERIOD, 7, expected period in sys_clk cycles; legal range 1..TIMEOUT.
- LOCK_CNT, 4, number of consecutive matching measurements required to assert locked; must be ≥1.
- TIMEOUT, 1024, cycles without a rising edge before timeout; legal range 2..2^CNT_W-1.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- strobe_in  in  1  asynchronous strobe under test; only rising edges matter.
- clr  in  1  synchronous clear, single-cycle pulse.
- period  out  CNT_W  last measured period in cycles.
- period_vld  out  1  one-cycle pulse when period is updated.
- locked  out  1  level; EXP_PERIOD matched LOCK_CNT times consecutively.
- mismatch  out  1  one-cycle pulse when a measurement is not equal to EXP_PERIOD.
- timeout  out  1  one-cycle pulse on loss of signal.

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk. All state and outputs are clocked on posedge sys_clk.
- Reset values:
  - period=0, period_vld=0, locked=0, mismatch=0, timeout=0.
  - Internal counter=0, match counter=0, state=IDLE, synchroniser flops=0.
- Input path:
  - strobe_in passes through a 2-flop synchroniser into s2, then one more flop s3.
  - rise = s2 & ~s3, a single-cycle pulse per rising edge.
  - Latency from the input edge to rise is 2–3 sys_clk cycles.
  - A stuck-high input produces exactly one rise.
- Counter cnt:
  - On rise, cnt<=1.
  - Otherwise cnt increments, saturating at TIMEOUT.
  - cnt is therefore the number of cycles since the last rise. Example: rise in cycles 10 and 17 gives period=7.
- FSM states: IDLE, MEAS, LOCKED.
  - IDLE: no reference edge yet. On rise, go to MEAS with cnt<=1. No measurement is produced.
  - MEAS or LOCKED, on rise:
    - period<=cnt and period_vld<=1 in the following cycle; cnt<=1.
    - If cnt==EXP_PERIOD, increment the match counter (saturating at LOCK_CNT).
    - When the match counter reaches LOCK_CNT, enter LOCKED and set locked<=1 in the same cycle as that period_vld.
    - If cnt!=EXP_PERIOD: mismatch<=1 for one cycle, match counter<=0, locked<=0, state<=MEAS.
  - MEAS or LOCKED, no rise and cnt==TIMEOUT:
    - timeout<=1 for one cycle, locked<=0, match counter<=0, state<=IDLE.
    - period holds its last value.
- Output timing: period_vld, mismatch, locked and timeout are all registered, one cycle after the deciding rise or counter condition.
- Simultaneous events:
  - rise in the same cycle as cnt==TIMEOUT: rise wins, and a valid measurement of TIMEOUT is taken.
  - clr has priority over everything. It forces state=IDLE, cnt=0, match counter=0, locked=0, and suppresses all pulses in that cycle.
  - period is not cleared by clr; it is cleared only by reset.
- sys_rst_n asserted mid-operation: everything returns to reset values immediately. The first rise after release only arms the block; it does not measure.
- Width rules: cnt is CNT_W bits. Its saturation at TIMEOUT guarantees it never wraps.

Decomposition:
- Shared package (meter_pkg):
  - state enum {IDLE, MEAS, LOCKED}.
  - Default constants for CNT_W, TIMEOUT, LOCK_CNT.
  - Elaboration checks: 1 ≤ EXP_PERIOD ≤ TIMEOUT < 2^CNT_W, and LOCK_CNT ≥ 1.
- Sub-module sync_rise_det:
  - Contains the 2-flop synchroniser, the edge flop and the rise output.
  - Reset via sys_rst_n.
  - Reusable by other GPIO-input blocks.

Test Plan:
1. Strobe every 7 cycles with defaults → first edge arms only. period_vld on every later edge with period=7, no mismatch. locked rises with the 4th period_vld and stays high.
2. Locked at 7, then one interval of 8 cycles → period=8, mismatch pulse, locked drops the same cycle. Four further 7-cycle intervals → locked reasserts.
3. Stop the strobe while locked → exactly one timeout pulse, 1024 cycles after the last rise. locked=0, state IDLE. Resuming at 7 needs 1 arming edge plus 4 measurements to relock.
4. Edge timed so rise coincides with cnt==1024 → period=1024, period_vld=1, mismatch=1, no timeout.
5. Assert clr mid-stream while locked, including clr in the same cycle as a rise → no period_vld in that cycle, locked=0, period unchanged. The next edge only arms.
6. Pull sys_rst_n low asynchronously mid-interval → all outputs read 0 without waiting for a clock edge. Hold strobe_in high during and after release → no measurement. Period only resumes after subsequent toggling.
